// File: rtl/mem_access_ctrl_if.sv
// Request and ram-port bundle for mem_access_ctrl.
// slave = the controller, master = the pipeline/ram side driving it.
interface mem_access_ctrl_if;
  // Handshake: the MEM stage raises req_valid_i and holds op/addr/wdata stable
  // while stall_o=1; the transfer finishes in the single cycle with done_o=1,
  // and a request seen during that cycle is not taken.
  logic        req_valid_i;
  logic [2:0]  req_op_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        ram_ce_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_data_o;
  logic        ram_hit1_i;
  logic        ram_hit2_i;
  logic [31:0] ram_data_i;
  logic        stall_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] rdata_o;

  modport slave (
    input  req_valid_i, req_op_i, req_addr_i, req_wdata_i,
    input  ram_hit1_i, ram_hit2_i, ram_data_i,
    output ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o,
    output stall_o, done_o, err_o, rdata_o
  );

  modport master (
    output req_valid_i, req_op_i, req_addr_i, req_wdata_i,
    output ram_hit1_i, ram_hit2_i, ram_data_i,
    input  ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o,
    input  stall_o, done_o, err_o, rdata_o
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store controller between the MEM stage and a variable-latency word ram.
// Define MEM_TIMEOUT_EN to add a watchdog that aborts RD/WR after TIMEOUT_CYCLES.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_ctrl_if.slave bus,
  output logic [2:0]       dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    GAP  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  state_t      state, state_n;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;
  logic [31:0] word_q;
  logic        err_q;
  logic        misaligned;
  logic        is_store_q;
  logic        hit;
  logic        tmo;

  // Big-endian lanes: byte offset 0 is bits 31:24, halfword offset 0 is 31:16.
  function automatic logic [31:0] load_extract(input logic [2:0] op,
                                               input logic [1:0] off,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (5'd24 - {off, 3'b000}));
    h = 16'(w >> (off[1] ? 5'd0 : 5'd16));
    case (op)
      OP_LB:   load_extract = {{24{b[7]}}, b};
      OP_LBU:  load_extract = {24'h0, b};
      OP_LH:   load_extract = {{16{h[15]}}, h};
      OP_LHU:  load_extract = {16'h0, h};
      default: load_extract = w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] op,
                                              input logic [1:0] off,
                                              input logic [31:0] w,
                                              input logic [15:0] d);
    logic [31:0] mask;
    logic [31:0] data;
    if (op == OP_SB) begin
      mask = 32'hFF00_0000 >> {off, 3'b000};
      data = {d[7:0], 24'h0} >> {off, 3'b000};
    end else begin
      mask = off[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
      data = off[1] ? {16'h0, d} : {d, 16'h0};
    end
    store_merge = (w & ~mask) | (data & mask);
  endfunction

  always_comb begin
    misaligned = 1'b0;
    case (bus.req_op_i)
      OP_LH, OP_LHU, OP_SH: misaligned = bus.req_addr_i[0];
      OP_LW, OP_SW:         misaligned = |bus.req_addr_i[1:0];
      default:              misaligned = 1'b0;
    endcase
  end

  assign is_store_q = op_q[2] & (op_q[1] | op_q[0]);
  assign hit        = bus.ram_hit1_i | bus.ram_hit2_i;

`ifdef MEM_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if ((state_n == RD || state_n == WR) && state_n != state) begin
      tmo_cnt <= '0;
    end else if (state == RD || state == WR) begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  assign tmo = (state == RD || state == WR) &&
               (tmo_cnt >= 32'(TIMEOUT_CYCLES) - 32'd1);
`else
  logic unused_timeout_cfg;
  assign tmo                = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n      = state;
    bus.stall_o  = 1'b0;
    bus.ram_ce_o = 1'b0;
    bus.ram_we_o = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid_i) begin
          bus.stall_o = 1'b1;
          if (misaligned)                 state_n = DONE;
          else if (bus.req_op_i == OP_SW) state_n = WR;
          else                            state_n = RD;
        end
      end
      RD: begin
        bus.stall_o  = 1'b1;
        bus.ram_ce_o = 1'b1;
        if (hit)      state_n = is_store_q ? GAP : DONE;
        else if (tmo) state_n = DONE;
      end
      // One idle cycle so the ram restarts its latency count before the write.
      GAP: begin
        bus.stall_o = 1'b1;
        state_n     = WR;
      end
      WR: begin
        bus.stall_o  = 1'b1;
        bus.ram_ce_o = 1'b1;
        bus.ram_we_o = 1'b1;
        if (bus.ram_hit2_i) state_n = DONE;
        else if (tmo)       state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      word_q      <= '0;
      err_q       <= 1'b0;
      bus.rdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            op_q    <= bus.req_op_i;
            addr_q  <= bus.req_addr_i;
            wdata_q <= bus.req_wdata_i[15:0];
            word_q  <= bus.req_wdata_i;
            err_q   <= misaligned;
          end
        end
        RD: begin
          if (hit) begin
            if (is_store_q) word_q <= store_merge(op_q, addr_q[1:0], bus.ram_data_i, wdata_q);
            else            bus.rdata_o <= load_extract(op_q, addr_q[1:0], bus.ram_data_i);
          end else if (tmo) begin
            err_q <= 1'b1;
          end
        end
        WR: begin
          if (!bus.ram_hit2_i && tmo) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ram_sel_o  = 4'hF;
  assign bus.ram_addr_o = {addr_q[31:2], 2'b00};
  assign bus.ram_data_o = (state == WR) ? word_q : 32'h0;
  assign bus.done_o     = (state == DONE);
  assign bus.err_o      = (state == DONE) && err_q;
  assign dbg_state_o    = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed spec cases plus randomized
// loads/stores against a byte-array reference model and a simulated ram.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  localparam int unsigned TMO = 8;
  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef struct {
    int          cyc;
    int          rd_n;
    int          wr_n;
    int          gap_n;
    bit          err;
    bit          any_ce;
    bit          stall_drop;
    bit          timed_out;
    bit          post_busy;
    logic [31:0] rdata;
    logic [31:0] wr_word;
    logic [31:0] rd_addr;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  dbg_state;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [logic [29:0]];
  logic [31:0] model_rdata;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "bench time limit");
  end

  // reference model
  function automatic logic [31:0] mem_rd(input logic [29:0] idx);
    if (!mem.exists(idx)) mem[idx] = $urandom;
    return mem[idx];
  endfunction

  function automatic int size_of(input logic [2:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      default:              return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [7:0] b [4];
    int k, v;
    for (int i = 0; i < 4; i++) b[i] = 8'(w >> (24 - 8 * i));
    k = int'(a % 4);
    case (op)
      OP_LB, OP_LBU: begin
        v = int'(b[k]);
        if (op == OP_LB && v >= 128) v -= 256;
      end
      OP_LH, OP_LHU: begin
        v = int'(b[k]) * 256 + int'(b[k + 1]);
        if (op == OP_LH && v >= 32768) v -= 65536;
      end
      default: return w;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_store(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] wd, input logic [31:0] old);
    logic [7:0] b [4];
    int k;
    if (op == OP_SW) return wd;
    for (int i = 0; i < 4; i++) b[i] = 8'(old >> (24 - 8 * i));
    k = int'(a % 4);
    if (op == OP_SB) begin
      b[k] = wd[7:0];
    end else begin
      b[k]     = wd[15:8];
      b[k + 1] = wd[7:0];
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  // driver tasks
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.ram_hit1_i  = 1'b0;
    bus.ram_hit2_i  = 1'b0;
    #1;
    rst = 1'b0;
  endtask

  // Issues one request and plays the ram: hit1 on the first RD cycle when
  // fast, else hit2 on RD cycle index lat; write acked on WR cycle index wlat.
  task automatic run_txn(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit fast, input int lat,
                         input int wlat, input int budget, output res_t r);
    r = '{default: 0};
    r.timed_out = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    while (r.cyc < budget) begin
      #1;
      bus.ram_hit1_i = 1'b0;
      bus.ram_hit2_i = 1'b0;
      bus.ram_data_i = $urandom;
      if (bus.done_o) begin
        r.timed_out = 1'b0;
        r.err       = bus.err_o;
        r.rdata     = bus.rdata_o;
        break;
      end
      if (!bus.stall_o) r.stall_drop = 1'b1;
      if (bus.ram_ce_o) r.any_ce = 1'b1;
      if (bus.ram_ce_o && !bus.ram_we_o) begin
        r.rd_addr = bus.ram_addr_o;
        if (fast && r.rd_n == 0) begin
          bus.ram_hit1_i = 1'b1;
          bus.ram_data_i = mem_rd(addr[31:2]);
        end else if (!fast && r.rd_n == lat) begin
          bus.ram_hit2_i = 1'b1;
          bus.ram_data_i = mem_rd(addr[31:2]);
        end
        r.rd_n++;
      end else if (bus.ram_ce_o && bus.ram_we_o) begin
        r.wr_word = bus.ram_data_o;
        if (r.wr_n == wlat) begin
          bus.ram_hit2_i = 1'b1;
          mem[bus.ram_addr_o[31:2]] = bus.ram_data_o;
        end
        r.wr_n++;
      end else if (r.rd_n > 0) begin
        r.gap_n++;
      end
      @(negedge clk);
      r.cyc++;
    end
    if (!r.timed_out) begin
      // request stays up through DONE; the cycle after must be idle, not a new access
      @(negedge clk);
      #1;
      r.post_busy = bus.ram_ce_o | bus.done_o;
      bus.req_valid_i = 1'b0;
    end
  endtask

  // tests
  task automatic test_reset();
    @(negedge clk);
    #1;
    n_tests++; if (bus.ram_ce_o !== 1'b0) begin n_fail++; $display("FAIL reset_ce: got %b want 0", bus.ram_ce_o); end
    n_tests++; if (bus.ram_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", bus.ram_we_o); end
    n_tests++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
    n_tests++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
    n_tests++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall_o); end
    n_tests++; if (bus.rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.rdata_o); end
    n_tests++; if (bus.ram_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.ram_addr_o); end
    n_tests++; if (bus.ram_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", bus.ram_data_o); end
    n_tests++; if (bus.ram_sel_o !== 4'hF) begin n_fail++; $display("FAIL reset_sel: got %h want f", bus.ram_sel_o); end
    rst = 1'b0;
  endtask

  task automatic test_loads();
    res_t r;
    mem[30'h4] = 32'h80FF1234;
    run_txn(OP_LW, 32'h10, 32'h0, 1'b1, 0, 0, 50, r);
    n_tests++; if (r.cyc != 2) begin n_fail++; $display("FAIL lw_latency: got %0d want 2", r.cyc); end
    n_tests++; if (r.rdata !== 32'h80FF1234) begin n_fail++; $display("FAIL lw_data: got %h want 80ff1234", r.rdata); end
    n_tests++; if (r.err) begin n_fail++; $display("FAIL lw_err: got 1 want 0"); end
    n_tests++; if (r.rd_addr !== 32'h10) begin n_fail++; $display("FAIL lw_addr: got %h want 00000010", r.rd_addr); end
    n_tests++; if (r.stall_drop || r.rd_n != 1) begin n_fail++; $display("FAIL lw_stall: drop=%0d rd_cycles=%0d want 0/1", r.stall_drop, r.rd_n); end
    n_tests++; if (r.post_busy) begin n_fail++; $display("FAIL done_no_accept: got busy after DONE want idle"); end

    run_txn(OP_LB, 32'h11, 32'h0, 1'b0, 3, 0, 50, r);
    n_tests++; if (r.rdata !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL lb_data: got %h want ffffffff", r.rdata); end
    n_tests++; if (r.cyc != 5) begin n_fail++; $display("FAIL lb_slow_latency: got %0d want 5", r.cyc); end
    n_tests++; if (r.rd_addr !== 32'h10) begin n_fail++; $display("FAIL lb_addr: got %h want 00000010", r.rd_addr); end

    run_txn(OP_LBU, 32'h11, 32'h0, 1'b1, 0, 0, 50, r);
    n_tests++; if (r.rdata !== 32'h000000FF) begin n_fail++; $display("FAIL lbu_data: got %h want 000000ff", r.rdata); end
    run_txn(OP_LHU, 32'h12, 32'h0, 1'b1, 0, 0, 50, r);
    n_tests++; if (r.rdata !== 32'h00001234) begin n_fail++; $display("FAIL lhu_data: got %h want 00001234", r.rdata); end
    run_txn(OP_LH, 32'h10, 32'h0, 1'b1, 0, 0, 50, r);
    n_tests++; if (r.rdata !== 32'hFFFF80FF) begin n_fail++; $display("FAIL lh_data: got %h want ffff80ff", r.rdata); end
  endtask

  task automatic test_stores();
    res_t r;
    mem[30'h4] = 32'h11223344;
    run_txn(OP_SB, 32'h13, 32'h000000AB, 1'b0, 201, 2, 400, r);
    n_tests++; if (r.gap_n != 1) begin n_fail++; $display("FAIL sb_gap: got %0d want 1", r.gap_n); end
    n_tests++; if (r.wr_word !== 32'h112233AB) begin n_fail++; $display("FAIL sb_word: got %h want 112233ab", r.wr_word); end
    n_tests++; if (r.cyc != 207) begin n_fail++; $display("FAIL sb_latency: got %0d want 207", r.cyc); end
    n_tests++; if (r.rdata !== 32'hFFFF80FF) begin n_fail++; $display("FAIL sb_rdata_hold: got %h want ffff80ff", r.rdata); end
    n_tests++; if (r.stall_drop || r.err) begin n_fail++; $display("FAIL sb_flags: stall_drop=%0d err=%0d want 0/0", r.stall_drop, r.err); end

    run_txn(OP_SH, 32'h10, 32'h00005566, 1'b1, 0, 0, 50, r);
    n_tests++; if (r.wr_word !== 32'h556633AB) begin n_fail++; $display("FAIL sh_word: got %h want 556633ab", r.wr_word); end
    n_tests++; if (r.cyc != 4) begin n_fail++; $display("FAIL sh_latency: got %0d want 4", r.cyc); end

    run_txn(OP_SW, 32'h14, 32'hDEADBEEF, 1'b1, 0, 1, 50, r);
    n_tests++; if (r.wr_word !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_word: got %h want deadbeef", r.wr_word); end
    n_tests++; if (r.cyc != 3 || r.rd_n != 0) begin n_fail++; $display("FAIL sw_path: cyc=%0d rd=%0d want 3/0", r.cyc, r.rd_n); end
  endtask

  task automatic test_misaligned();
    res_t r;
    logic [2:0]  ops   [5];
    logic [31:0] addrs [5];
    ops   = '{OP_LH, OP_SW, OP_LW, OP_SH, OP_LHU};
    addrs = '{32'h21, 32'h22, 32'h23, 32'h25, 32'h27};
    for (int i = 0; i < 5; i++) begin
      run_txn(ops[i], addrs[i], 32'h12345678, 1'b1, 0, 0, 20, r);
      n_tests++;
      if (r.cyc != 1 || !r.err || r.any_ce) begin
        n_fail++;
        $display("FAIL misaligned_%0d: cyc=%0d err=%0d ce=%0d want 1/1/0", i, r.cyc, r.err, r.any_ce);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    res_t r;
    logic [31:0] exp_word;
    exp_word = mem_rd(30'hC);
    run_txn(OP_SW, 32'h30, 32'hCAFEF00D, 1'b1, 0, -1, 4, r);
    n_tests++; if (!r.timed_out || r.wr_n != 3) begin n_fail++; $display("FAIL rst_setup: timed_out=%0d wr=%0d want 1/3", r.timed_out, r.wr_n); end
    #1;
    rst = 1'b1;
    bus.req_valid_i = 1'b0;
    #1;
    n_tests++; if (bus.ram_ce_o !== 1'b0 || bus.ram_we_o !== 1'b0) begin n_fail++; $display("FAIL rst_async_ce: got ce=%b we=%b want 0/0", bus.ram_ce_o, bus.ram_we_o); end
    n_tests++; if (bus.stall_o !== 1'b0 || bus.done_o !== 1'b0 || bus.err_o !== 1'b0) begin n_fail++; $display("FAIL rst_async_flags: stall=%b done=%b err=%b want 0", bus.stall_o, bus.done_o, bus.err_o); end
    n_tests++; if (bus.rdata_o !== 32'h0 || bus.ram_data_o !== 32'h0 || bus.ram_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_async_data: rdata=%h wdata=%h addr=%h want 0", bus.rdata_o, bus.ram_data_o, bus.ram_addr_o); end
    rst = 1'b0;
    run_txn(OP_LW, 32'h30, 32'h0, 1'b1, 0, 0, 50, r);
    n_tests++; if (r.timed_out || r.cyc != 2 || r.err) begin n_fail++; $display("FAIL rst_then_lw: timeout=%0d cyc=%0d err=%0d want 0/2/0", r.timed_out, r.cyc, r.err); end
    n_tests++; if (r.rdata !== exp_word) begin n_fail++; $display("FAIL rst_then_lw_data: got %h want %h", r.rdata, exp_word); end
  endtask

  task automatic test_timeout();
    res_t r;
`ifdef MEM_TIMEOUT_EN
    run_txn(OP_LW, 32'h40, 32'h0, 1'b0, -1, 0, 100, r);
    n_tests++; if (r.timed_out || r.cyc != 1 + TMO) begin n_fail++; $display("FAIL tmo_rd_cycle: timeout=%0d cyc=%0d want 0/%0d", r.timed_out, r.cyc, 1 + TMO); end
    n_tests++; if (!r.err || r.rd_n != TMO) begin n_fail++; $display("FAIL tmo_rd_err: err=%0d rd=%0d want 1/%0d", r.err, r.rd_n, TMO); end
    run_txn(OP_SW, 32'h44, 32'h1, 1'b0, 0, -1, 100, r);
    n_tests++; if (r.timed_out || !r.err || r.wr_n != TMO) begin n_fail++; $display("FAIL tmo_wr: timeout=%0d err=%0d wr=%0d want 0/1/%0d", r.timed_out, r.err, r.wr_n, TMO); end
`else
    run_txn(OP_LW, 32'h40, 32'h0, 1'b0, -1, 0, 40, r);
    #1;
    n_tests++; if (!r.timed_out || bus.stall_o !== 1'b1) begin n_fail++; $display("FAIL no_tmo_wait: timed_out=%0d stall=%b want 1/1", r.timed_out, bus.stall_o); end
    n_tests++; if (bus.ram_ce_o !== 1'b1 || r.rd_n != 39) begin n_fail++; $display("FAIL no_tmo_rd: ce=%b rd=%0d want 1/39", bus.ram_ce_o, r.rd_n); end
    pulse_reset();
`endif
  endtask

  task automatic test_random();
    res_t r;
    logic [2:0]  op;
    logic [31:0] a, wd, old, exp_w, exp_rd;
    bit          fast, mis, st;
    int          lat, wlat, exp_cyc, rcyc, wcyc;
    pulse_reset();
    model_rdata = 32'h0;
    for (int i = 0; i < 60; i++) begin
      op   = 3'($urandom_range(0, 7));
      a    = 32'($urandom_range(0, 63));
      wd   = $urandom;
      fast = 1'($urandom_range(0, 1));
      lat  = $urandom_range(0, 5);
      wlat = $urandom_range(0, 4);
      mis  = (a % size_of(op)) != 0;
      st   = op >= OP_SB;
      old  = mem_rd(a[31:2]);
      rcyc = fast ? 1 : lat + 1;
      wcyc = wlat + 1;
      if (mis)               exp_cyc = 1;
      else if (op == OP_SW)  exp_cyc = 1 + wcyc;
      else if (st)           exp_cyc = 2 + rcyc + wcyc;
      else                   exp_cyc = 1 + rcyc;
      if (!mis && !st) model_rdata = ref_load(op, a, old);
      exp_q.push_back(model_rdata);
      exp_w = ref_store(op, a, wd, old);
      run_txn(op, a, wd, fast, lat, wlat, 100, r);
      exp_rd = exp_q.pop_front();
      n_tests++; if (r.rdata !== exp_rd) begin n_fail++; $display("FAIL rnd_rdata[%0d] op=%0d a=%h: got %h want %h", i, op, a, r.rdata, exp_rd); end
      n_tests++; if (r.err != mis || r.cyc != exp_cyc) begin n_fail++; $display("FAIL rnd_timing[%0d] op=%0d a=%h: err=%0d cyc=%0d want %0d/%0d", i, op, a, r.err, r.cyc, mis, exp_cyc); end
      if (st && !mis) begin
        n_tests++; if (r.wr_word !== exp_w) begin n_fail++; $display("FAIL rnd_store[%0d] op=%0d a=%h: got %h want %h", i, op, a, r.wr_word, exp_w); end
      end
      if (!mis && op != OP_SW) begin
        n_tests++; if (r.rd_addr !== {a[31:2], 2'b00}) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, r.rd_addr, {a[31:2], 2'b00}); end
      end
      if (mis) begin
        n_tests++; if (r.any_ce) begin n_fail++; $display("FAIL rnd_mis_ce[%0d]: ram accessed on misaligned request", i); end
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.req_op_i    = 3'd0;
    bus.req_addr_i  = 32'h0;
    bus.req_wdata_i = 32'h0;
    bus.ram_hit1_i  = 1'b0;
    bus.ram_hit2_i  = 1'b0;
    bus.ram_data_i  = 32'h0;
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_reset_mid_write();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
